image_stream_reader: RTL and testbench

- Reads one full frame out of the block-RAM image store in raster order and presents it as a valid/ready pixel stream with frame and line markers.
- Sits directly downstream of the image memory. Drives that memory's address and consumes its registered 24-bit read data, which has 1-cycle latency.
- Feeds the filter pipeline.
- Absorbs the memory read latency under backpressure, so throughput is 1 pixel/clk when the consumer is always ready.

---
 rtl/image_pkg.sv | 38 +++
 rtl/stream_fifo2.sv | 60 ++++++
 rtl/image_stream_reader.sv | 141 ++++++++++++++
 tb/tb_image_stream_reader.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/image_pkg.sv
// Shared geometry, pixel and stream-beat types for the image pipeline.
package image_pkg;

  localparam int IMG_WIDTH  = 320;
  localparam int IMG_HEIGHT = 240;
  localparam int IMG_ADDR_W = 17;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  typedef logic [IMG_ADDR_W-1:0] pix_addr_t;

  typedef struct packed {
    pixel_t data;
    logic   sof;
    logic   eol;
    logic   eof;
  } stream_beat_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN
  } reader_state_t;

  function automatic stream_beat_t make_beat(logic [23:0] rgb, logic sof, logic eol, logic eof);
    stream_beat_t beat;
    beat.data = rgb;
    beat.sof  = sof;
    beat.eol  = eol;
    beat.eof  = eof;
    return beat;
  endfunction

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry FIFO of stream beats; an empty FIFO presents valid=0 and zero data.
module stream_fifo2
  import image_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              push_i,
  input  logic [$bits(stream_beat_t)-1:0]   push_beat_i,
  input  logic                              pop_i,
  output logic                              valid_o,
  output logic [$bits(stream_beat_t)-1:0]   beat_o,
  output logic [1:0]                        count_o
);

  localparam int BW = $bits(stream_beat_t);

  logic [BW-1:0] mem_q [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    count_q, count_d;
  logic          do_push, do_pop;

  assign do_push = push_i && (count_q != 2'd2);
  assign do_pop  = pop_i && (count_q != 2'd0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ~wr_ptr_q;
    if (do_pop)  rd_ptr_d = ~rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: it is only visible through a non-zero count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_beat_i;
  end

  assign valid_o = (count_q != 2'd0);
  assign beat_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/image_stream_reader.sv
// Streams one frame from the image store in raster order as a valid/ready
// pixel stream with sof/eol/eof markers, hiding the 1-cycle memory latency.
module image_stream_reader
  import image_pkg::*;
#(
  parameter int WIDTH  = IMG_WIDTH,
  parameter int HEIGHT = IMG_HEIGHT,
  parameter int ADDR_W = IMG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [23:0]       mem_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [23:0]       m_data,
  output logic              m_sof,
  output logic              m_eol,
  output logic              m_eof,
  output logic              done
);

  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [XW-1:0]     X_LAST    = XW'(WIDTH - 1);
  localparam logic [XW-1:0]     X_ONE     = XW'(1);
  localparam logic [YW-1:0]     Y_LAST    = YW'(HEIGHT - 1);
  localparam logic [YW-1:0]     Y_ONE     = YW'(1);

  reader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic              inflight_q, inflight_d;
  logic [2:0]        flags_q, flags_d;
  logic              done_q, done_d;
  logic              issue;

  stream_beat_t mem_beat, fifo_beat, out_beat;
  logic         fifo_valid, fifo_push, fifo_pop, handshake;
  logic [1:0]   fifo_count;
  logic [2:0]   occupancy;

  // Data returning this cycle bypasses the FIFO when it is empty and the
  // consumer is ready, which is what gives 1 pixel/clk with no bubble.
  assign mem_beat  = make_beat(mem_data, flags_q[2], flags_q[1], flags_q[0]);
  assign m_valid   = fifo_valid || inflight_q;
  assign out_beat  = fifo_valid ? fifo_beat : (inflight_q ? mem_beat : '0);
  assign handshake = m_valid && m_ready;
  assign fifo_pop  = fifo_valid && m_ready;
  assign fifo_push = inflight_q && !(!fifo_valid && m_ready);
  assign occupancy = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, handshake};

  stream_fifo2 u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .push_beat_i (mem_beat),
    .pop_i       (fifo_pop),
    .valid_o     (fifo_valid),
    .beat_o      (fifo_beat),
    .count_o     (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    x_d     = x_q;
    y_d     = y_q;
    flags_d = {(x_q == '0) && (y_q == '0), x_q == X_LAST, (x_q == X_LAST) && (y_q == Y_LAST)};
    done_d  = 1'b0;
    issue   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        addr_d = '0;
        x_d    = '0;
        y_d    = '0;
        // done_q still high means this is the completion cycle; start is dropped.
        if (start && !done_q) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (occupancy < 3'd2) begin
          issue = 1'b1;
          if (addr_q == LAST_ADDR) begin
            state_d = ST_DRAIN;
          end else begin
            addr_d = addr_q + ADDR_ONE;
            if (x_q == X_LAST) begin
              x_d = '0;
              y_d = y_q + Y_ONE;
            end else begin
              x_d = x_q + X_ONE;
            end
          end
        end
      end
      ST_DRAIN: begin
        if (handshake && out_beat.eof) begin
          state_d = ST_IDLE;
          addr_d  = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    inflight_d = issue;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      inflight_q <= 1'b0;
      flags_q    <= 3'b000;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      x_q        <= x_d;
      y_q        <= y_d;
      inflight_q <= inflight_d;
      flags_q    <= flags_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign mem_addr = addr_q;
  assign done     = done_q;
  assign m_data   = out_beat.data;
  assign m_sof    = out_beat.sof;
  assign m_eol    = out_beat.eol;
  assign m_eof    = out_beat.eof;

endmodule

// File: tb/tb_image_stream_reader.sv
// Scoreboard bench: a 4x3 reader for directed frame tests plus a full-size
// reader for one complete 320x240 frame.
module tb_image_stream_reader;
  import image_pkg::*;

  localparam int SW  = 4;
  localparam int SH  = 3;
  localparam int SAW = 4;
  localparam int SN  = SW * SH;
  localparam int LN  = IMG_WIDTH * IMG_HEIGHT;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // Small instance
  logic           sStart, sBusy, sValid, sReady, sSof, sEol, sEof, sDone;
  logic [SAW-1:0] sAddr;
  logic [23:0]    sMemData, sData;

  // Full-size instance
  logic                  lStart, lBusy, lValid, lReady, lSof, lEol, lEof, lDone;
  logic [IMG_ADDR_W-1:0] lAddr;
  logic [23:0]           lMemData, lData;

  image_stream_reader #(.WIDTH(SW), .HEIGHT(SH), .ADDR_W(SAW)) dutS (
    .clk(clk), .rst(rst), .start(sStart), .busy(sBusy), .mem_addr(sAddr),
    .mem_data(sMemData), .m_valid(sValid), .m_ready(sReady), .m_data(sData),
    .m_sof(sSof), .m_eol(sEol), .m_eof(sEof), .done(sDone)
  );

  image_stream_reader dutL (
    .clk(clk), .rst(rst), .start(lStart), .busy(lBusy), .mem_addr(lAddr),
    .mem_data(lMemData), .m_valid(lValid), .m_ready(lReady), .m_data(lData),
    .m_sof(lSof), .m_eol(lEol), .m_eof(lEof), .done(lDone)
  );

  // Memory models: registered read, data equals address
  always @(posedge clk) sMemData <= 24'(sAddr);
  always @(posedge clk) lMemData <= 24'(lAddr);

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [23:0] data;
    logic        sof;
    logic        eol;
    logic        eof;
    int          expCyc;
  } exp_t;

  exp_t sbQ[$];
  int   doneExp[$];
  bit   checkLead = 1'b0;
  int   accepted = 0;
  bit   prevStall = 1'b0;
  logic [23:0] prevData;
  logic [2:0]  prevFlags;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input bit big);
    if (big) lStart = 1'b1;
    else sStart = 1'b1;
    stepCycles(1);
    lStart = 1'b0;
    sStart = 1'b0;
  endtask

  // Expected frame: data = pixel index, markers from raster position
  task automatic pushFrame(input int startCyc);
    exp_t e;
    for (int i = 0; i < SN; i++) begin
      e.data   = 24'(i);
      e.sof    = (i == 0);
      e.eol    = ((i % SW) == SW - 1);
      e.eof    = (i == SN - 1);
      e.expCyc = (startCyc < 0) ? -1 : startCyc + 2 + i;
      sbQ.push_back(e);
    end
  endtask

  task automatic waitDone(input string name, input int budget, output int doneCyc);
    doneCyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sDone) begin
        doneCyc = cycle;
        break;
      end
    end
    if (doneCyc < 0) begin
      checks++;
      $display("[TB] FAIL %s: done not seen within %0d cycles", name, budget);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor for the small instance: pops the scoreboard on every handshake
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prevStall = 1'b0;
      accepted  = 0;
    end else begin
      if (!sBusy) accepted = 0;
      if (prevStall) begin
        checkOutput("stall valid", 32'(sValid), 32'd1);
        checkOutput("stall data", 32'(sData), 32'(prevData));
        checkOutput("stall flags", 32'({sSof, sEol, sEof}), 32'(prevFlags));
      end
      if (checkLead && sBusy)
        checkOutput("addr lead", 32'((int'(sAddr) - accepted) <= 2), 32'd1);
      if (sValid) checkOutput("valid only while busy", 32'(sBusy), 32'd1);
      if (sValid && sReady) begin
        if (sbQ.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected beat: got data %0d with empty scoreboard", sData);
        end else begin
          e = sbQ.pop_front();
          checkOutput("beat data", 32'(sData), 32'(e.data));
          checkOutput("beat flags", 32'({sSof, sEol, sEof}), 32'({e.sof, e.eol, e.eof}));
          if (e.expCyc >= 0) checkOutput("beat cycle", 32'(cycle), 32'(e.expCyc));
        end
        accepted++;
        if (sEof) doneExp.push_back(cycle + 1);
      end
      if (sDone) begin
        if (doneExp.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected done: got done at cycle %0d with no eof beat", cycle);
        end else begin
          checkOutput("done cycle", 32'(cycle), 32'(doneExp.pop_front()));
        end
        checkOutput("busy low at done", 32'(sBusy), 32'd0);
      end
      prevStall = sValid && !sReady;
      prevData  = sData;
      prevFlags = {sSof, sEol, sEof};
    end
  end

  // Monitor for the full-size instance: accumulates frame statistics
  int bigBeats = 0, bigDataErr = 0, bigEolErr = 0, bigEolCount = 0;
  int bigSofCount = 0, bigEofCount = 0, bigEofIdx = -1, bigDoneCount = 0, bigMaxAddr = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (int'(lAddr) > bigMaxAddr) bigMaxAddr = int'(lAddr);
      if (lValid && lReady) begin
        if (lData !== 24'(bigBeats)) bigDataErr++;
        if (lEol !== ((bigBeats % IMG_WIDTH) == IMG_WIDTH - 1)) bigEolErr++;
        if (lEol) bigEolCount++;
        if (lSof) bigSofCount++;
        if (lEof) begin
          bigEofCount++;
          bigEofIdx = bigBeats;
        end
        bigBeats++;
      end
      if (lDone) bigDoneCount++;
    end
  end

  initial begin
    int k, r, dc;
    rst    = 1'b1;
    sStart = 1'b0;
    sReady = 1'b0;
    lStart = 1'b0;
    lReady = 1'b1;
    stepCycles(3);
    checkOutput("reset valid", 32'(sValid), 32'd0);
    checkOutput("reset busy", 32'(sBusy), 32'd0);
    checkOutput("reset addr", 32'(sAddr), 32'd0);
    checkOutput("reset done", 32'(sDone), 32'd0);
    checkOutput("reset data", 32'(sData), 32'd0);
    rst = 1'b0;

    // Test 1: always-ready frame started at cycle 10
    while (cycle < 10) stepCycles(1);
    sReady = 1'b1;
    k = cycle;
    pushFrame(k);
    applyStimulus(1'b0);
    checkOutput("t1 busy after start", 32'(sBusy), 32'd1);
    checkOutput("t1 first addr", 32'(sAddr), 32'd0);
    waitDone("t1 done", 60, dc);
    checkOutput("t1 done cycle", 32'(dc), 32'(k + 14));
    checkOutput("t1 busy after done", 32'(sBusy), 32'd0);
    checkOutput("t1 beats left", 32'(sbQ.size()), 32'd0);

    // Test 2: ready alternating 1,0 from the first beat
    sReady = 1'b0;
    stepCycles(2);
    k = cycle;
    pushFrame(-1);
    applyStimulus(1'b0);
    checkLead = 1'b1;
    dc = -1;
    for (int i = 0; i < 100 && dc < 0; i++) begin
      sReady = (cycle >= k + 2) && (((cycle - k - 2) % 2) == 0);
      @(negedge clk);
      if (sDone) dc = cycle;
      @(posedge clk);
      #1;
    end
    if (dc < 0) begin
      checks++;
      $display("[TB] FAIL t2 done: done not seen within 100 cycles");
    end
    checkLead = 1'b0;
    sReady = 1'b1;
    checkOutput("t2 beats left", 32'(sbQ.size()), 32'd0);

    // Test 3: ready held low for 20 cycles after start
    sReady = 1'b0;
    stepCycles(2);
    k = cycle;
    pushFrame(-1);
    applyStimulus(1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("t3 held addr", 32'(sAddr), 32'((i >= 2) ? 2 : i));
      checkOutput("t3 held valid", 32'(sValid), 32'(i >= 1));
      if (i >= 1) checkOutput("t3 held data", 32'(sData), 32'd0);
      @(posedge clk);
      #1;
    end
    r = cycle;
    for (int i = 0; i < sbQ.size(); i++) sbQ[i].expCyc = r + i;
    sReady = 1'b1;
    waitDone("t3 done", 60, dc);
    checkOutput("t3 done cycle", 32'(dc), 32'(r + SN));

    // Test 4: start during busy and in the done cycle ignored; next cycle restarts
    stepCycles(2);
    k = cycle;
    pushFrame(k);
    applyStimulus(1'b0);
    while (cycle < k + 7) stepCycles(1);
    sStart = 1'b1;
    stepCycles(1);
    sStart = 1'b0;
    checkOutput("t4 busy after mid start", 32'(sBusy), 32'd1);
    while (cycle < k + 14) stepCycles(1);
    pushFrame(k + 15);
    sStart = 1'b1;
    @(negedge clk);
    checkOutput("t4 done with start", 32'(sDone), 32'd1);
    @(posedge clk);
    #1;
    stepCycles(1);
    sStart = 1'b0;
    checkOutput("t4 restart busy", 32'(sBusy), 32'd1);
    checkOutput("t4 restart addr", 32'(sAddr), 32'd0);
    waitDone("t4 done", 60, dc);
    checkOutput("t4 second done cycle", 32'(dc), 32'(k + 29));

    // Test 5: async reset mid-frame at beat 6, then clean restart
    stepCycles(2);
    k = cycle;
    pushFrame(k);
    applyStimulus(1'b0);
    while (cycle < k + 8) stepCycles(1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("t5 rst valid", 32'(sValid), 32'd0);
    checkOutput("t5 rst busy", 32'(sBusy), 32'd0);
    checkOutput("t5 rst addr", 32'(sAddr), 32'd0);
    checkOutput("t5 rst done", 32'(sDone), 32'd0);
    sbQ.delete();
    doneExp.delete();
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    stepCycles(1);
    k = cycle;
    pushFrame(k);
    applyStimulus(1'b0);
    waitDone("t5 done", 60, dc);
    checkOutput("t5 done cycle", 32'(dc), 32'(k + 14));

    // Test 6: one full 320x240 frame on the default-size instance
    lReady = 1'b1;
    k = cycle;
    applyStimulus(1'b1);
    dc = -1;
    for (int i = 0; i < LN + 100 && dc < 0; i++) begin
      @(negedge clk);
      if (lDone) dc = cycle;
    end
    if (dc < 0) begin
      checks++;
      $display("[TB] FAIL t6 done: done not seen within %0d cycles", LN + 100);
    end
    stepCycles(5);
    checkOutput("t6 done cycle", 32'(dc), 32'(k + 2 + LN));
    checkOutput("t6 beat count", 32'(bigBeats), 32'(LN));
    checkOutput("t6 data errors", 32'(bigDataErr), 32'd0);
    checkOutput("t6 max addr", 32'(bigMaxAddr), 32'(LN - 1));
    checkOutput("t6 eof count", 32'(bigEofCount), 32'd1);
    checkOutput("t6 eof index", 32'(bigEofIdx), 32'(LN - 1));
    checkOutput("t6 eol count", 32'(bigEolCount), 32'(IMG_HEIGHT));
    checkOutput("t6 eol placement errors", 32'(bigEolErr), 32'd0);
    checkOutput("t6 sof count", 32'(bigSofCount), 32'd1);
    checkOutput("t6 done count", 32'(bigDoneCount), 32'd1);
    checkOutput("t6 busy after", 32'(lBusy), 32'd0);

    checkOutput("final scoreboard empty", 32'(sbQ.size()), 32'd0);
    checkOutput("final done queue empty", 32'(doneExp.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
